// File: rtl/lmu_pchinfo_buf.sv
// Patch-info buffer: circular FIFO of {last, pchop1, pchop0, facebd_n, pchtype} entries.
// The head is read show-ahead; pchinfo_valid is raised only once a whole array is buffered.

`ifndef PCHTYPE_BW
`define PCHTYPE_BW 4
`endif
`ifndef FACEBD_BW
`define FACEBD_BW 3
`endif
`ifndef OPCODE_BW
`define OPCODE_BW 8
`endif

module lmu_pchinfo_buf #(
    parameter int DEPTH  = 16,
    parameter int PTR_BW = 4
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    pchinfo_in_valid,
    output logic                    pchinfo_in_ready,
    input  logic [`PCHTYPE_BW-1:0]  pchtype_in,
    input  logic [`FACEBD_BW-1:0]   facebd_n_in,
    input  logic [`OPCODE_BW-1:0]   pchop0_in,
    input  logic [`OPCODE_BW-1:0]   pchop1_in,
    input  logic                    pchinfo_in_last,

    output logic                    pchinfo_valid,
    output logic [`PCHTYPE_BW-1:0]  pchtype,
    output logic [`FACEBD_BW-1:0]   facebd_n,
    output logic [`OPCODE_BW-1:0]   pchop0,
    output logic [`OPCODE_BW-1:0]   pchop1,
    output logic                    pchinfo_rdlast,
    input  logic                    pchinfo_pop,

    output logic [PTR_BW:0]         occupancy,
    output logic                    ovf_err,
    output logic                    udf_err
);

    typedef struct packed {
        logic                   last;
        logic [`OPCODE_BW-1:0]  pchop1;
        logic [`OPCODE_BW-1:0]  pchop0;
        logic [`FACEBD_BW-1:0]  facebd_n;
        logic [`PCHTYPE_BW-1:0] pchtype;
    } entry_t;

    localparam logic [PTR_BW:0] FULL_CNT = (PTR_BW + 1)'(DEPTH);

    entry_t              mem_q [DEPTH];
    logic [PTR_BW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_BW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_BW:0]     occ_q, occ_d;
    logic [PTR_BW:0]     array_cnt_q, array_cnt_d;
    logic                ovf_q, ovf_d;
    logic                udf_q, udf_d;

    entry_t              wr_entry;
    entry_t              head;
    logic                empty;
    logic                wr_en;
    logic                rd_en;
    logic                arr_inc;
    logic                arr_dec;

    assign empty            = (occ_q == '0);
    assign pchinfo_in_ready = (occ_q != FULL_CNT);
    assign wr_en            = pchinfo_in_valid & pchinfo_in_ready;
    assign rd_en            = pchinfo_pop & ~empty;

    assign wr_entry = '{last:     pchinfo_in_last,
                        pchop1:   pchop1_in,
                        pchop0:   pchop0_in,
                        facebd_n: facebd_n_in,
                        pchtype:  pchtype_in};

    // Stale memory contents never leak: the head is forced to zero while empty.
    assign head = empty ? '0 : mem_q[rd_ptr_q];

    assign pchtype        = head.pchtype;
    assign facebd_n       = head.facebd_n;
    assign pchop0         = head.pchop0;
    assign pchop1         = head.pchop1;
    assign pchinfo_rdlast = ~empty & head.last;
    assign pchinfo_valid  = (array_cnt_q != '0);
    assign occupancy      = occ_q;
    assign ovf_err        = ovf_q;
    assign udf_err        = udf_q;

    assign arr_inc = wr_en & pchinfo_in_last;
    assign arr_dec = rd_en & head.last;

    always_comb begin
        // NOTE: every next-state variable gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        array_cnt_d = array_cnt_q;
        ovf_d       = ovf_q | (pchinfo_in_valid & ~pchinfo_in_ready);
        udf_d       = udf_q | (pchinfo_pop & empty);

        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;

        unique case ({wr_en, rd_en})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase

        unique case ({arr_inc, arr_dec})
            2'b10:   array_cnt_d = array_cnt_q + 1'b1;
            2'b01:   array_cnt_d = array_cnt_q - 1'b1;
            default: array_cnt_d = array_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            array_cnt_q <= '0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            array_cnt_q <= array_cnt_d;
            ovf_q       <= ovf_d;
            udf_q       <= udf_d;
        end
    end

    // NOTE: the storage array has no reset; occupancy gating makes its power-up contents irrelevant.
    always_ff @(posedge clk) begin
        if (wr_en & ~rst) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

endmodule

// File: tb/tb_lmu_pchinfo_buf.sv
// Self-checking bench for lmu_pchinfo_buf: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based model of the buffer.

`ifndef PCHTYPE_BW
`define PCHTYPE_BW 4
`endif
`ifndef FACEBD_BW
`define FACEBD_BW 3
`endif
`ifndef OPCODE_BW
`define OPCODE_BW 8
`endif

module tb_lmu_pchinfo_buf;

    localparam int DEPTH  = 16;
    localparam int PTR_BW = 4;
    localparam int PT = `PCHTYPE_BW;
    localparam int FB = `FACEBD_BW;
    localparam int OP = `OPCODE_BW;
    localparam int EW = 1 + 2 * OP + FB + PT;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [PT-1:0]   pchtype_in;
    logic [FB-1:0]   facebd_n_in;
    logic [OP-1:0]   pchop0_in;
    logic [OP-1:0]   pchop1_in;
    logic            in_last;
    logic            out_valid;
    logic [PT-1:0]   pchtype;
    logic [FB-1:0]   facebd_n;
    logic [OP-1:0]   pchop0;
    logic [OP-1:0]   pchop1;
    logic            rdlast;
    logic            pop;
    logic [PTR_BW:0] occupancy;
    logic            ovf_err;
    logic            udf_err;

    lmu_pchinfo_buf #(.DEPTH(DEPTH), .PTR_BW(PTR_BW)) dut (
        .clk              (clk),
        .rst              (rst),
        .pchinfo_in_valid (in_valid),
        .pchinfo_in_ready (in_ready),
        .pchtype_in       (pchtype_in),
        .facebd_n_in      (facebd_n_in),
        .pchop0_in        (pchop0_in),
        .pchop1_in        (pchop1_in),
        .pchinfo_in_last  (in_last),
        .pchinfo_valid    (out_valid),
        .pchtype          (pchtype),
        .facebd_n         (facebd_n),
        .pchop0           (pchop0),
        .pchop1           (pchop1),
        .pchinfo_rdlast   (rdlast),
        .pchinfo_pop      (pop),
        .occupancy        (occupancy),
        .ovf_err          (ovf_err),
        .udf_err          (udf_err)
    );

    always #5 clk = ~clk;

    // Reference model: the buffer contents as an ordered queue of packed entries.
    logic [EW-1:0] model_q[$];
    logic          m_ovf;
    logic          m_udf;
    logic          model_known = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] rand_entry(input logic last);
        logic [PT-1:0] t;
        logic [FB-1:0] f;
        logic [OP-1:0] o0;
        logic [OP-1:0] o1;
        t  = PT'($urandom);
        f  = FB'($urandom);
        o0 = OP'($urandom);
        o1 = OP'($urandom);
        return {last, o1, o0, f, t};
    endfunction

    task automatic check_outputs();
        logic [EW-1:0] h;
        logic          any_last;
        any_last = 1'b0;
        foreach (model_q[i]) any_last |= model_q[i][EW-1];
        h = (model_q.size() != 0) ? model_q[0] : '0;
        check("occupancy", 32'(occupancy), 32'(model_q.size()));
        check("in_ready",  32'(in_ready),  32'(model_q.size() != DEPTH));
        check("valid",     32'(out_valid), 32'(any_last));
        check("rdlast",    32'(rdlast),    32'(h[EW-1]));
        check("pchtype",   32'(pchtype),   32'(h[PT-1:0]));
        check("facebd_n",  32'(facebd_n),  32'(h[PT+FB-1:PT]));
        check("pchop0",    32'(pchop0),    32'(h[PT+FB+OP-1:PT+FB]));
        check("pchop1",    32'(pchop1),    32'(h[PT+FB+2*OP-1:PT+FB+OP]));
        check("ovf_err",   32'(ovf_err),   32'(m_ovf));
        check("udf_err",   32'(udf_err),   32'(m_udf));
    endtask

    task automatic model_edge(input logic r, input logic v, input logic [EW-1:0] e, input logic p);
        bit wr;
        bit rd;
        if (r) begin
            model_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            wr = v && (model_q.size() < DEPTH);
            rd = p && (model_q.size() != 0);
            if (v && !wr) m_ovf = 1'b1;
            if (p && model_q.size() == 0) m_udf = 1'b1;
            if (rd) model_q.delete(0);
            if (wr) model_q.push_back(e);
        end
    endtask

    // One clock: check current outputs, drive inputs, advance the model across the edge.
    task automatic cycle(input logic r, input logic v, input logic [EW-1:0] e, input logic p);
        if (model_known) check_outputs();
        rst         = r;
        in_valid    = v;
        in_last     = e[EW-1];
        pchop1_in   = e[PT+FB+2*OP-1:PT+FB+OP];
        pchop0_in   = e[PT+FB+OP-1:PT+FB];
        facebd_n_in = e[PT+FB-1:PT];
        pchtype_in  = e[PT-1:0];
        pop         = p;
        @(posedge clk);
        model_edge(r, v, e, p);
        if (r) model_known = 1'b1;
        @(negedge clk);
    endtask

    task automatic wr(input logic last);
        cycle(1'b0, 1'b1, rand_entry(last), 1'b0);
    endtask

    task automatic rd();
        cycle(1'b0, 1'b0, '0, 1'b1);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, '0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; pop = 1'b0; in_last = 1'b0;
        pchtype_in = '0; facebd_n_in = '0; pchop0_in = '0; pchop1_in = '0;
        m_ovf = 1'b0; m_udf = 1'b0;
        @(negedge clk);

        // Reset, with a write presented in the same cycle that must be discarded.
        cycle(1'b1, 1'b1, rand_entry(1'b1), 1'b0);
        do_reset();

        // Array of three entries: valid rises only after the last one lands.
        wr(1'b0); wr(1'b0); wr(1'b1);
        check_outputs();

        // Drain it with three back-to-back pops.
        rd(); rd(); rd();

        // Fill completely with a partial array, then overflow with a 17th entry.
        for (int i = 0; i < DEPTH; i++) wr(1'b0);
        wr(1'b1);
        wr(1'b0);
        // Drain the partial array: legal, no error beyond the overflow already seen.
        for (int i = 0; i < DEPTH; i++) rd();

        // Underflow: pop while empty.
        rd();
        do_reset();

        // Simultaneous write(last) and pop of a lone last entry.
        wr(1'b1);
        cycle(1'b0, 1'b1, rand_entry(1'b1), 1'b1);
        rd();

        // Interleaved traffic across the pointer wrap boundary.
        for (int i = 0; i < 20; i++) begin
            wr(1'($urandom_range(0, 1)));
            cycle(1'b0, 1'b1, rand_entry(1'($urandom_range(0, 1))), 1'b1);
            rd();
        end

        // Reset with five entries holding two complete arrays, plus a pending error.
        do_reset();
        rd();
        wr(1'b0); wr(1'b1); wr(1'b0); wr(1'b1); wr(1'b0);
        cycle(1'b1, 1'b1, rand_entry(1'b1), 1'b0);
        check_outputs();

        // Randomized traffic in fill-biased and drain-biased phases.
        for (int ph = 0; ph < 6; ph++) begin
            for (int i = 0; i < 120; i++) begin
                logic v;
                logic p;
                logic r;
                v = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 80 : 30));
                p = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 30 : 80));
                r = ($urandom_range(0, 199) == 0);
                cycle(r, v, rand_entry(($urandom_range(0, 99) < 30)), p);
            end
        end
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
